// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core: memory-op descriptor, access sizes,
// MEM-stage FSM states and exception codes.
package mips_cpu_pkg;

    typedef logic [4:0]  reg_enum;
    typedef logic [63:0] double_word_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } memsz_enum;

    typedef struct packed {
        logic      ld;
        logic      st;
        memsz_enum sz;
        logic      uns;
    } memop_struct;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_DONE = 2'd2
    } mem_state_enum;

    typedef logic [1:0] excp_t;
    localparam excp_t EXC_NONE = 2'd0;
    localparam excp_t EXC_ADEL = 2'd1;
    localparam excp_t EXC_ADES = 2'd2;
    localparam excp_t EXC_DBE  = 2'd3;

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    // Handshake: the master raises dbus_req with stable we/be/addr/wdata and holds
    // them until the slave pulses dbus_ack for exactly one cycle; dbus_rdata is
    // valid only in that ack cycle. The request drops the cycle after the ack.
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for the MEM stage: byte enables, store replication,
// misalign detection (request side) and load extract/extend (response side).
module mem_lane_fmt
    import mips_cpu_pkg::*;
(
    input  memsz_enum   sz,
    input  logic [1:0]  alo,
    input  logic [31:0] din,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    input  memsz_enum   ld_sz,
    input  logic [1:0]  ld_alo,
    input  logic        ld_uns,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    logic [31:0] lane;

    always_comb begin
        be       = 4'b1111;
        wdata    = din;
        misalign = 1'b0;
        case (sz)
            SZ_B: begin
                be    = 4'b0001 << alo;
                wdata = {4{din[7:0]}};
            end
            SZ_H: begin
                be       = 4'b0011 << alo;
                wdata    = {2{din[15:0]}};
                misalign = alo[0];
            end
            default: misalign = (alo != 2'b00);
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    assign lane = rdata >> {ld_alo, 3'b000};

    always_comb begin
        ld_data = lane;
        case (ld_sz)
            SZ_B:    ld_data = {{24{lane[7] & ~ld_uns}}, lane[7:0]};
            SZ_H:    ld_data = {{16{lane[15] & ~ld_uns}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: runs loads/stores over the req/ack data bus with a timeout,
// stalls upstream while an access is in flight and feeds MEM/WB.
module mem_stage
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
)(
    input  logic          cpu_clk_50M,
    input  logic          cpu_rst_n,
    input  logic          mem_i_dm2rf,
    input  logic          mem_i_hilowe,
    input  logic          mem_i_rfwe,
    input  reg_enum       mem_i_rfwa,
    input  double_word_t  mem_i_mulres,
    input  logic [31:0]   mem_i_alures,
    input  logic [31:0]   mem_i_dmdin,
    input  memop_struct   mem_i_memop,
    mem_stage_if.master   dbus,
    output logic          mem_o_stall,
    output logic          mem_o_rfwe,
    output reg_enum       mem_o_rfwa,
    output logic          mem_o_hilowe,
    output double_word_t  mem_o_mulres,
    output logic [31:0]   mem_o_wbdata,
    output excp_t         mem_o_excp,
    output mem_state_enum mem_o_state
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    mem_state_enum state, state_nxt;
    logic [CW-1:0] cnt;
    logic          buserr;
    logic [31:0]   rdbuf;
    logic [1:0]    alo_q;
    memsz_enum     sz_q;
    logic          uns_q;

    logic [3:0]    fmt_be;
    logic [31:0]   fmt_wdata;
    logic [31:0]   fmt_ld;
    logic          misalign;
    logic          access;
    logic          timed_out;

    mem_lane_fmt u_fmt (
        .sz      (mem_i_memop.sz),
        .alo     (mem_i_alures[1:0]),
        .din     (mem_i_dmdin),
        .be      (fmt_be),
        .wdata   (fmt_wdata),
        .misalign(misalign),
        .ld_sz   (sz_q),
        .ld_alo  (alo_q),
        .ld_uns  (uns_q),
        .rdata   (dbus.dbus_rdata),
        .ld_data (fmt_ld)
    );

    assign access    = mem_i_memop.ld | mem_i_memop.st;
    // The REQ cycle in which cnt is TIMEOUT_CYC-1 is the last one allowed.
    assign timed_out = (cnt == CW'(TIMEOUT_CYC - 1));

    assign dbus.dbus_req = (state == MS_REQ);
    assign mem_o_rfwa    = mem_i_rfwa;
    assign mem_o_mulres  = mem_i_mulres;
    assign mem_o_state   = state;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state           <= MS_IDLE;
            cnt             <= '0;
            buserr          <= 1'b0;
            rdbuf           <= '0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_be    <= '0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wdata <= '0;
            alo_q           <= '0;
            sz_q            <= SZ_B;
            uns_q           <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                MS_IDLE: if (access && !misalign) begin
                    dbus.dbus_we    <= mem_i_memop.st;
                    dbus.dbus_be    <= fmt_be;
                    dbus.dbus_addr  <= {mem_i_alures[31:2], 2'b00};
                    dbus.dbus_wdata <= fmt_wdata;
                    alo_q           <= mem_i_alures[1:0];
                    sz_q            <= mem_i_memop.sz;
                    uns_q           <= mem_i_memop.uns;
                end
                MS_REQ: if (dbus.dbus_ack) begin
                    rdbuf <= fmt_ld;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (timed_out) buserr <= 1'b1;
                end
                MS_DONE: begin
                    cnt    <= '0;
                    buserr <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_o_stall  = 1'b0;
        mem_o_rfwe   = mem_i_rfwe;
        mem_o_hilowe = mem_i_hilowe;
        mem_o_wbdata = mem_i_alures;
        mem_o_excp   = EXC_NONE;
        case (state)
            MS_IDLE: if (access) begin
                mem_o_rfwe   = 1'b0;
                mem_o_hilowe = 1'b0;
                if (misalign) begin
                    mem_o_excp = mem_i_memop.ld ? EXC_ADEL : EXC_ADES;
                end else begin
                    mem_o_stall = 1'b1;
                    state_nxt   = MS_REQ;
                end
            end
            MS_REQ: begin
                mem_o_stall  = 1'b1;
                mem_o_rfwe   = 1'b0;
                mem_o_hilowe = 1'b0;
                if (dbus.dbus_ack || timed_out) state_nxt = MS_DONE;
            end
            MS_DONE: begin
                // Held instruction retires on this edge; IDLE never sees it again.
                state_nxt = MS_IDLE;
                if (mem_i_dm2rf) mem_o_wbdata = rdbuf;
                if (buserr) begin
                    mem_o_excp   = EXC_DBE;
                    mem_o_rfwe   = 1'b0;
                    mem_o_hilowe = 1'b0;
                end
            end
            default: state_nxt = MS_IDLE;
        endcase
        if (!cpu_rst_n) begin
            mem_o_stall  = 1'b0;
            mem_o_rfwe   = 1'b0;
            mem_o_hilowe = 1'b0;
            mem_o_excp   = EXC_NONE;
        end
    end
endmodule
